// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and the pattern/colour stage.
// The generator drives every signal; the colour stage only observes.
interface vga_timing_gen_if;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output hsync, vsync, display_on, hpos, vpos, frame_start, frame_count
    );

    modport slave (
        input  hsync, vsync, display_on, hpos, vpos, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing: pixel/line counters, registered syncs and
// display flag, a frame-start strobe and an 8-bit frame counter.
module vga_timing_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_timing_gen_if.master    vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_display_on;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    logic       w_h_wrap;
    logic [9:0] w_hpos_next;
    logic [9:0] w_vpos_next;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_vs_rise;

    // Flags are decoded from the next-state counters so they land in the same
    // cycle as the coordinates they describe.
    assign w_h_wrap    = (r_hpos == H_LAST);
    assign w_hpos_next = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
    assign w_vpos_next = !w_h_wrap        ? r_vpos :
                         (r_vpos == V_LAST) ? 10'd0 : r_vpos + 10'd1;

    assign w_hs_act  = (w_hpos_next >= H_SYNC_START) && (w_hpos_next <= H_SYNC_END);
    assign w_vs_act  = (w_vpos_next >= V_SYNC_START) && (w_vpos_next <= V_SYNC_END);
    assign w_vs_rise = w_vs_act && (r_vsync != SYNC_ACTIVE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_display_on  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_hpos        <= w_hpos_next;
            r_vpos        <= w_vpos_next;
            r_hsync       <= w_hs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= w_vs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_display_on  <= (w_hpos_next < H_VISIBLE) && (w_vpos_next < V_VISIBLE);
            r_frame_start <= (w_hpos_next == 10'd0) && (w_vpos_next == 10'd0);
            if (w_vs_rise) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign vga.hpos        = r_hpos;
    assign vga.vpos        = r_vpos;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.display_on  = r_display_on;
    assign vga.frame_start = r_frame_start;
    assign vga.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x525 instance for reset/line/async-reset behaviour,
// a 14x7 override instance for whole-frame, frame_count and wrap behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    vga_timing_gen_if vga_a ();
    vga_timing_gen_if vga_b ();

    vga_timing_gen u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .vga   (vga_a)
    );

    vga_timing_gen #(
        .H_DISPLAY   (8),
        .H_FRONT     (2),
        .H_SYNC      (2),
        .H_BACK      (2),
        .V_DISPLAY   (4),
        .V_FRONT     (1),
        .V_SYNC      (1),
        .V_BACK      (1),
        .SYNC_ACTIVE (1'b1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .vga   (vga_b)
    );

    always #5 clk = ~clk;

    // Expected raster position / frame count of the small instance.
    logic [9:0] bh;
    logic [9:0] bv;
    logic [7:0] bfc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 14 clocks per line, 7 lines per frame; count bumps on entering line 5.
    task automatic b_step();
        if (bh == 10'd13) begin
            bh = 10'd0;
            bv = (bv == 10'd6) ? 10'd0 : bv + 10'd1;
        end else begin
            bh = bh + 10'd1;
        end
        if (bh == 10'd0 && bv == 10'd5) bfc = bfc + 8'd1;
    endtask

    int   hs_cnt;
    int   de_cnt;
    int   fs_cnt;
    int   fs_gap;
    int   last_fs;
    int   vs_cnt;
    logic [7:0] prev_fc;
    logic wrapped;
    logic found;

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (5) tick();

        check("a_rst_hpos",  32'(vga_a.hpos), 32'd799);
        check("a_rst_vpos",  32'(vga_a.vpos), 32'd524);
        check("a_rst_hsync", 32'(vga_a.hsync), 32'd1);
        check("a_rst_vsync", 32'(vga_a.vsync), 32'd1);
        check("a_rst_de",    32'(vga_a.display_on), 32'd0);
        check("a_rst_fs",    32'(vga_a.frame_start), 32'd0);
        check("a_rst_fc",    32'(vga_a.frame_count), 32'd0);
        check("b_rst_hpos",  32'(vga_b.hpos), 32'd13);
        check("b_rst_vpos",  32'(vga_b.vpos), 32'd6);
        check("b_rst_hsync", 32'(vga_b.hsync), 32'd0);
        check("b_rst_vsync", 32'(vga_b.vsync), 32'd0);

        rst_n_a = 1'b1;
        tick();
        check("a_first_hpos", 32'(vga_a.hpos), 32'd0);
        check("a_first_vpos", 32'(vga_a.vpos), 32'd0);
        check("a_first_de",   32'(vga_a.display_on), 32'd1);
        check("a_first_fs",   32'(vga_a.frame_start), 32'd1);
        tick();
        check("a_fs_drop",    32'(vga_a.frame_start), 32'd0);

        // One full line at the default timing.
        hs_cnt = 0;
        de_cnt = 1;
        for (int i = 1; i < 800; i++) begin
            check("a_line_hpos",  32'(vga_a.hpos), 32'(i));
            check("a_line_vpos",  32'(vga_a.vpos), 32'd0);
            check("a_line_de",    32'(vga_a.display_on), 32'(i < 640));
            check("a_line_hsync", 32'(vga_a.hsync), 32'(!(i >= 656 && i <= 751)));
            check("a_line_vsync", 32'(vga_a.vsync), 32'd1);
            check("a_line_fs",    32'(vga_a.frame_start), 32'd0);
            if (!vga_a.hsync)     hs_cnt++;
            if (vga_a.display_on) de_cnt++;
            tick();
        end
        check("a_wrap_hpos",  32'(vga_a.hpos), 32'd0);
        check("a_wrap_vpos",  32'(vga_a.vpos), 32'd1);
        check("a_wrap_de",    32'(vga_a.display_on), 32'd1);
        check("a_wrap_fs",    32'(vga_a.frame_start), 32'd0);
        check("a_hsync_len",  32'(hs_cnt), 32'd96);
        check("a_de_len",     32'(de_cnt), 32'd640);

        repeat (300) tick();
        check("a_mid_hpos", 32'(vga_a.hpos), 32'd300);
        check("a_mid_vpos", 32'(vga_a.vpos), 32'd1);

        // Asynchronous reset between edges, observed before the next edge.
        #2 rst_n_a = 1'b0;
        #1;
        check("a_async_hpos", 32'(vga_a.hpos), 32'd799);
        check("a_async_vpos", 32'(vga_a.vpos), 32'd524);
        check("a_async_de",   32'(vga_a.display_on), 32'd0);
        check("a_async_hs",   32'(vga_a.hsync), 32'd1);
        check("a_async_fc",   32'(vga_a.frame_count), 32'd0);
        tick();
        rst_n_a = 1'b1;
        tick();
        check("a_restart_hpos", 32'(vga_a.hpos), 32'd0);
        check("a_restart_vpos", 32'(vga_a.vpos), 32'd0);
        check("a_restart_fs",   32'(vga_a.frame_start), 32'd1);

        // Small instance: two full frames checked cycle by cycle.
        rst_n_b = 1'b1;
        tick();
        bh  = 10'd0;
        bv  = 10'd0;
        bfc = 8'd0;
        check("b_first_hpos", 32'(vga_b.hpos), 32'd0);
        check("b_first_vpos", 32'(vga_b.vpos), 32'd0);
        check("b_first_fs",   32'(vga_b.frame_start), 32'd1);
        check("b_first_de",   32'(vga_b.display_on), 32'd1);
        check("b_first_fc",   32'(vga_b.frame_count), 32'd0);

        fs_cnt  = 0;
        fs_gap  = 0;
        last_fs = 0;
        vs_cnt  = 0;
        for (int c = 1; c <= 196; c++) begin
            tick();
            b_step();
            check("b_hpos",  32'(vga_b.hpos), 32'(bh));
            check("b_vpos",  32'(vga_b.vpos), 32'(bv));
            check("b_hsync", 32'(vga_b.hsync), 32'(bh == 10'd10 || bh == 10'd11));
            check("b_vsync", 32'(vga_b.vsync), 32'(bv == 10'd5));
            check("b_de",    32'(vga_b.display_on), 32'(bh < 10'd8 && bv < 10'd4));
            check("b_fs",    32'(vga_b.frame_start), 32'(bh == 10'd0 && bv == 10'd0));
            check("b_fc",    32'(vga_b.frame_count), 32'(bfc));
            if (vga_b.frame_start) begin
                fs_cnt++;
                fs_gap  = c - last_fs;
                last_fs = c;
            end
            if (vga_b.vsync) vs_cnt++;
        end
        check("b_fs_count",    32'(fs_cnt), 32'd2);
        check("b_fs_period",   32'(fs_gap), 32'd98);
        check("b_vsync_clks",  32'(vs_cnt), 32'd28);
        check("b_fc_2frames",  32'(vga_b.frame_count), 32'd2);

        // Run on until the frame counter rolls over 255 -> 0.
        prev_fc = vga_b.frame_count;
        wrapped = 1'b0;
        for (int c = 0; c < 30000 && !wrapped; c++) begin
            tick();
            b_step();
            if (bh == 10'd0 && bv == 10'd0) begin
                check("b_fc_frame", 32'(vga_b.frame_count), 32'(bfc));
            end
            if (bh == 10'd0 && bv == 10'd5 && bfc == 8'd0) begin
                wrapped = 1'b1;
                check("b_fc_before_wrap", 32'(prev_fc), 32'd255);
                check("b_fc_wrap",        32'(vga_b.frame_count), 32'd0);
            end
            prev_fc = vga_b.frame_count;
        end
        check("b_wrap_reached", 32'(wrapped), 32'd1);

        // Mid-frame asynchronous reset with a non-zero frame count.
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            tick();
            b_step();
            if (bh == 10'd3 && bv == 10'd2 && bfc == 8'd1) found = 1'b1;
        end
        check("b_mid_reached", 32'(found), 32'd1);
        check("b_mid_fc",      32'(vga_b.frame_count), 32'd1);
        check("b_mid_de",      32'(vga_b.display_on), 32'd1);
        #2 rst_n_b = 1'b0;
        #1;
        check("b_async_hpos", 32'(vga_b.hpos), 32'd13);
        check("b_async_vpos", 32'(vga_b.vpos), 32'd6);
        check("b_async_fc",   32'(vga_b.frame_count), 32'd0);
        check("b_async_de",   32'(vga_b.display_on), 32'd0);
        check("b_async_hs",   32'(vga_b.hsync), 32'd0);
        check("b_async_vs",   32'(vga_b.vsync), 32'd0);
        tick();
        rst_n_b = 1'b1;
        tick();
        check("b_restart_hpos", 32'(vga_b.hpos), 32'd0);
        check("b_restart_vpos", 32'(vga_b.vpos), 32'd0);
        check("b_restart_fs",   32'(vga_b.frame_start), 32'd1);
        check("b_restart_fc",   32'(vga_b.frame_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
